bcd_tc_serial_conv: RTL and testbench
=====================================

# bcd_tc_serial_conv

Sequential converter that receives an N‑digit ten's‑complement BCD number one digit at a time, most significant digit first, over a dav_/rfd handshake. It accumulates the value with a shared multiply‑by‑ten‑and‑add step, applies the ten's‑to‑two's‑complement correction, and delivers the W‑bit two's‑complement result over a second handshake. It sits between a digit‑serial producer (keypad or serial front end) and any consumer of signed binary operands.

## Interface
- N, default 2: number of BCD digits per number.
- W, default 7: result width; 2^W >= 10^N is required.
- clock  in  1  system clock; all state changes on its rising edge.
- reset_  in  1  asynchronous, active‑low reset.
- digit  in  4  BCD digit; valid while dav_=0.
- dav_  in  1  producer data valid, active low.
- rfd  out  1  ready for data, active high.
- result  out  W  two's‑complement value; stable while out_dav_=0.
- err  out  1  set when any digit of the current number exceeded 9; stable while out_dav_=0.
- out_dav_  out  1  result valid, active low.
- out_rfd  in  1  consumer ready, active high.

## Operation
- Reset values: rfd=1, out_dav_=1, result=0, err=0; internal acc=0, cnt=0, neg=0, state WAIT_DIG.
- States:
  - WAIT_DIG: rfd=1. If dav_=0, go to LOAD.
  - LOAD: one cycle; rfd=0. acc <= acc*10 + digit (truncated to W bits). If cnt=0, neg <= (digit >= 5). If digit > 9, err_int <= 1. cnt <= cnt+1. Go to WAIT_END.
  - WAIT_END: rfd=0. On dav_=1: go to CORR if cnt=N, else to WAIT_DIG.
  - CORR: one cycle. result <= neg ? acc + (2^W − 10^N) mod 2^W : acc. err <= err_int. If err_int=1, result <= 0.
  - OUT: out_dav_=0. If out_rfd=0, go to OUT_END.
  - OUT_END: out_dav_=1. On out_rfd=1, clear acc, cnt, neg and err_int, then go to WAIT_DIG.
- An invalid digit is still consumed and counted. The number completes normally with err=1 and result=0.
- Arithmetic: acc*10 is formed on W+4 bits and truncated to W. Truncation is exact because each partial value is below 10^N ≤ 2^W. For N=2 and W=7 the correction constant is 28.
- result and err hold their values until the next CORR.
- Reset asserted in any state, mid‑number or mid‑output, returns all signals to their reset values asynchronously. The partial number is discarded.
- A dav_ glitch high while in LOAD has no effect; dav_ is sampled only in WAIT_DIG and WAIT_END.

## Timing
- rfd falls one cycle after the edge that samples dav_=0, i.e. on entry to LOAD.
- Minimum per‑digit cycle is 3 clocks: WAIT_DIG → LOAD → WAIT_END → WAIT_DIG.
- Latency: out_dav_ goes low 2 rising edges after the edge that samples dav_=1 for the Nth digit (WAIT_END → CORR → OUT).
- out_dav_ returns high on the edge following sampled out_rfd=0. rfd returns high on the edge following sampled out_rfd=1.
- The block does not accept a new digit while an output handshake is in progress. rfd stays 0 from LOAD of the Nth digit until the return to WAIT_DIG.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Structure
- Shared package:
  - state enum (WAIT_DIG, LOAD, WAIT_END, CORR, OUT, OUT_END)
  - function POW10(N)
  - correction constant CORR_K = 2^W − 10^N
  - cnt width clog2(N+1)
- Sub‑module mul10_add: combinational, parameter W; inputs acc[W], d[4]; output (acc*10 + d) truncated to W. It is implemented with shift‑adds (acc<<3 + acc<<1 + d).

## Test plan
- Reset, then digits 4, 9 → out_dav_=0 with result=7'b0110001 (49), err=0; latency of 2 edges checked.
- Digits 5, 0 → result=7'h4E (−50); digits 9, 9 → result=7'h7F (−1); digits 0, 0 → result=0.
- Digits 1, 4'hC → err=1, result=0. The next number, 2, 3, gives result=23 with err=0 (error cleared).
- Reset_ pulsed low after the first digit 7 → rfd=1, out_dav_=1 immediately. Then 0, 7 → result=7.
- Slow consumer: out_rfd held 1 for 20 cycles while out_dav_=0. result stays stable, rfd stays 0, and a dav_=0 pulse from the producer is ignored.
- Back‑to‑back numbers at minimum handshake pace, 1000 random valid pairs checked against a reference model (value ≥ 50 → value − 100).

Source files
------------

// File: rtl/bcd_tc_serial_conv_pkg.sv
// Shared definitions for the digit-serial ten's-complement BCD to two's-complement converter.
package bcd_tc_serial_conv_pkg;

  typedef logic [2:0] state_t;

  localparam state_t WAIT_DIG = 3'd0;
  localparam state_t LOAD     = 3'd1;
  localparam state_t WAIT_END = 3'd2;
  localparam state_t CORR     = 3'd3;
  localparam state_t OUT      = 3'd4;
  localparam state_t OUT_END  = 3'd5;

  function automatic int POW10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Adding 2^W - 10^N maps a ten's-complement magnitude onto its two's-complement code.
  function automatic int corr_k(input int w, input int n);
    return (1 << w) - POW10(n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bcd_tc_serial_conv_mul10_add.sv
// Shift-add step acc*10 + d, truncated to W bits.
module mul10_add #(
  parameter int W = 7
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   d,
  output logic [W-1:0] y
);

  // Sums are taken modulo 2^W; the dropped high bits never affect the low W bits.
  assign y = (acc << 3) + (acc << 1) + W'(d);

endmodule

// File: rtl/bcd_tc_serial_conv.sv
// Accepts N ten's-complement BCD digits MSD first and returns the W-bit two's-complement value.
module bcd_tc_serial_conv
  import bcd_tc_serial_conv_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic [3:0]   digit,
  input  logic         dav_,
  output logic         rfd,
  output logic [W-1:0] result,
  output logic         err,
  output logic         out_dav_,
  input  logic         out_rfd
);

  localparam int                 CNT_W    = cnt_w(N);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(N);
  localparam logic [W-1:0]       CORR_K   = W'(corr_k(W, N));

  state_t           state;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_next;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             err_int;

  mul10_add #(.W(W)) u_mul10_add (
    .acc (acc),
    .d   (digit),
    .y   (acc_next)
  );

  assign rfd      = (state == WAIT_DIG);
  assign out_dav_ = (state != OUT);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state   <= WAIT_DIG;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      err_int <= 1'b0;
      result  <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        WAIT_DIG: if (!dav_) state <= LOAD;
        LOAD: begin
          acc <= acc_next;
          // Sign lives in the leading digit: 5..9 means the number is negative.
          if (cnt == '0) neg <= (digit >= 4'd5);
          if (digit > 4'd9) err_int <= 1'b1;
          cnt   <= cnt + 1'b1;
          state <= WAIT_END;
        end
        WAIT_END: if (dav_) state <= (cnt == CNT_LAST) ? CORR : WAIT_DIG;
        CORR: begin
          if (err_int) result <= '0;
          else         result <= neg ? acc + CORR_K : acc;
          err   <= err_int;
          state <= OUT;
        end
        OUT: if (!out_rfd) state <= OUT_END;
        OUT_END: begin
          if (out_rfd) begin
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            err_int <= 1'b0;
            state   <= WAIT_DIG;
          end
        end
        default: state <= WAIT_DIG;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_tc_serial_conv.sv
// Randomized and directed bench for bcd_tc_serial_conv with an arithmetic reference model.
module tb_bcd_tc_serial_conv;

  localparam int N = 2;
  localparam int W = 7;

  logic         clock;
  logic         reset_;
  logic [3:0]   digit;
  logic         dav_;
  logic         rfd;
  logic [W-1:0] result;
  logic         err;
  logic         out_dav_;
  logic         out_rfd;

  int tests;
  int fails;

  bcd_tc_serial_conv #(.N(N), .W(W)) dut (
    .clock    (clock),
    .reset_   (reset_),
    .digit    (digit),
    .dav_     (dav_),
    .rfd      (rfd),
    .result   (result),
    .err      (err),
    .out_dav_ (out_dav_),
    .out_rfd  (out_rfd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: two-digit ten's complement, values 50..99 stand for value-100.
  function automatic logic [W-1:0] model_res(input int a, input int b);
    int v;
    if (a > 9 || b > 9) return '0;
    v = a * 10 + b;
    if (v >= 50) v = v - 100;
    return W'(v);
  endfunction

  task automatic send_digit(input int d);
    int k;
    @(negedge clock);
    k = 0;
    while (!rfd && k < 50) begin @(negedge clock); k++; end
    digit = 4'(d);
    dav_  = 1'b0;
    k = 0;
    do begin @(negedge clock); k++; end while (rfd && k < 50);
    dav_ = 1'b1;
    if (k >= 50) begin
      tests++; fails++;
      $display("FAIL send_digit timeout: rfd=%0b required 0", rfd);
    end
  endtask

  task automatic send_pair(input int a, input int b);
    send_digit(a);
    send_digit(b);
  endtask

  task automatic read_out(output logic [W-1:0] r, output logic e, output bit ok);
    int k;
    k = 0;
    while (out_dav_ && k < 30) begin @(negedge clock); k++; end
    ok = !out_dav_;
    r  = result;
    e  = err;
    out_rfd = 1'b0;
    @(negedge clock);
    out_rfd = 1'b1;
  endtask

  task automatic test_reset;
    reset_ = 1'b0;
    repeat (2) @(negedge clock);
    tests++; if (rfd !== 1'b1)      begin fails++; $display("FAIL reset_rfd: got %0b required 1", rfd); end
    tests++; if (out_dav_ !== 1'b1) begin fails++; $display("FAIL reset_out_dav: got %0b required 1", out_dav_); end
    tests++; if (result !== '0)     begin fails++; $display("FAIL reset_result: got %0h required 0", result); end
    tests++; if (err !== 1'b0)      begin fails++; $display("FAIL reset_err: got %0b required 0", err); end
    reset_ = 1'b1;
  endtask

  task automatic test_latency;
    send_pair(4, 9);
    @(negedge clock);
    @(negedge clock);
    tests++; if (out_dav_ !== 1'b1) begin fails++; $display("FAIL latency_early: out_dav_=%0b required 1", out_dav_); end
    tests++; if (rfd !== 1'b0)      begin fails++; $display("FAIL latency_rfd: rfd=%0b required 0", rfd); end
    @(negedge clock);
    tests++; if (out_dav_ !== 1'b0) begin fails++; $display("FAIL latency_2edges: out_dav_=%0b required 0", out_dav_); end
    tests++; if (result !== 7'b0110001) begin fails++; $display("FAIL result_49: got %0h required 31", result); end
    tests++; if (err !== 1'b0)      begin fails++; $display("FAIL err_49: got %0b required 0", err); end
    out_rfd = 1'b0;
    @(negedge clock);
    tests++; if (out_dav_ !== 1'b1) begin fails++; $display("FAIL out_dav_release: got %0b required 1", out_dav_); end
    tests++; if (rfd !== 1'b0)      begin fails++; $display("FAIL rfd_out_end: got %0b required 0", rfd); end
    out_rfd = 1'b1;
    @(negedge clock);
    tests++; if (rfd !== 1'b1)      begin fails++; $display("FAIL rfd_return: got %0b required 1", rfd); end
    tests++; if (result !== 7'd49)  begin fails++; $display("FAIL result_hold: got %0h required 31", result); end
  endtask

  task automatic test_values;
    logic [W-1:0] r;
    logic e;
    bit ok;
    int a[4]     = '{5, 9, 0, 0};
    int b[4]     = '{0, 9, 0, 7};
    logic [W-1:0] x[4] = '{7'h4E, 7'h7F, 7'h00, 7'h07};
    for (int i = 0; i < 4; i++) begin
      send_pair(a[i], b[i]);
      read_out(r, e, ok);
      tests++; if (!ok)       begin fails++; $display("FAIL value_timeout %0d%0d: out_dav_ never low", a[i], b[i]); end
      tests++; if (r !== x[i]) begin fails++; $display("FAIL value %0d%0d: got %0h required %0h", a[i], b[i], r, x[i]); end
      tests++; if (e !== 1'b0) begin fails++; $display("FAIL value_err %0d%0d: got %0b required 0", a[i], b[i], e); end
    end
  endtask

  task automatic test_invalid_digit;
    logic [W-1:0] r;
    logic e;
    bit ok;
    send_pair(1, 12);
    read_out(r, e, ok);
    tests++; if (!ok || r !== '0) begin fails++; $display("FAIL invalid_result: got %0h ok=%0b required 0", r, ok); end
    tests++; if (e !== 1'b1)      begin fails++; $display("FAIL invalid_err: got %0b required 1", e); end
    @(negedge clock);
    tests++; if (err !== 1'b1)    begin fails++; $display("FAIL invalid_err_hold: got %0b required 1", err); end
    send_pair(2, 3);
    read_out(r, e, ok);
    tests++; if (!ok || r !== 7'd23) begin fails++; $display("FAIL after_err_result: got %0h required 17", r); end
    tests++; if (e !== 1'b0)         begin fails++; $display("FAIL after_err_err: got %0b required 0", e); end
  endtask

  task automatic test_mid_reset;
    logic [W-1:0] r;
    logic e;
    bit ok;
    int k;
    @(negedge clock);
    digit = 4'd7;
    dav_  = 1'b0;
    k = 0;
    do begin @(negedge clock); k++; end while (rfd && k < 50);
    reset_ = 1'b0;
    #1;
    tests++; if (rfd !== 1'b1)      begin fails++; $display("FAIL async_reset_rfd: got %0b required 1", rfd); end
    tests++; if (out_dav_ !== 1'b1) begin fails++; $display("FAIL async_reset_out_dav: got %0b required 1", out_dav_); end
    dav_ = 1'b1;
    @(negedge clock);
    reset_ = 1'b1;
    send_pair(0, 7);
    read_out(r, e, ok);
    tests++; if (!ok || r !== 7'd7) begin fails++; $display("FAIL post_reset_value: got %0h required 7", r); end
  endtask

  task automatic test_slow_consumer;
    logic [W-1:0] r;
    logic e;
    bit ok;
    int k;
    bit bad;
    send_pair(3, 6);
    k = 0;
    while (out_dav_ && k < 30) begin @(negedge clock); k++; end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin digit = 4'd5; dav_ = 1'b0; end
      if (i == 9) dav_ = 1'b1;
      @(negedge clock);
      if (out_dav_ !== 1'b0 || rfd !== 1'b0 || result !== 7'd36) bad = 1'b1;
    end
    tests++; if (bad) begin fails++; $display("FAIL slow_consumer: out_dav_=%0b rfd=%0b result=%0h required 0/0/24", out_dav_, rfd, result); end
    out_rfd = 1'b0;
    @(negedge clock);
    out_rfd = 1'b1;
    send_pair(1, 2);
    read_out(r, e, ok);
    tests++; if (!ok || r !== 7'd12) begin fails++; $display("FAIL after_slow: got %0h required 0c", r); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] r;
    logic [W-1:0] x;
    logic e;
    bit ok;
    int a, b, nbad;
    nbad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(9));
      b = int'($urandom_range(9));
      x = model_res(a, b);
      send_pair(a, b);
      read_out(r, e, ok);
      tests++;
      if (!ok || r !== x || e !== 1'b0) begin
        fails++;
        if (nbad < 10) $display("FAIL random %0d%0d: got %0h err=%0b required %0h", a, b, r, e, x);
        nbad++;
      end
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_  = 1'b0;
    digit   = 4'd0;
    dav_    = 1'b1;
    out_rfd = 1'b1;
    test_reset();
    test_latency();
    test_values();
    test_invalid_digit();
    test_mid_reset();
    test_slow_consumer();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
